// File: rtl/sram_port_arbiter.sv
// Request/grant arbiter sharing one single-port tile SRAM bank between the SPI
// host path and the tile processor, with read-return routing and conflict counting.
module sram_port_arbiter #(
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 8,
   parameter int MAX_HOST_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_gnt,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   input  logic              t_req,
   input  logic              t_we,
   input  logic [ADDR_W-1:0] t_addr,
   input  logic [DATA_W-1:0] t_wdata,
   output logic              t_gnt,
   output logic              t_rvalid,
   output logic [DATA_W-1:0] t_rdata,
   output logic              m_ce,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_din,
   input  logic [DATA_W-1:0] m_dout,
   output logic [15:0]       conflict_cnt
);

   localparam logic [3:0] MAX_B = 4'(MAX_HOST_BURST);

   logic [3:0]        r_streak;
   logic [15:0]       r_conflict_cnt;
   logic              r_rd_vld_p1;
   logic              r_rd_host_p1;
   logic [ADDR_W-1:0] r_addr_hold;
   logic [DATA_W-1:0] r_din_hold;
   logic [DATA_W-1:0] r_h_rdata_hold;
   logic [DATA_W-1:0] r_t_rdata_hold;

   logic              w_both;
   logic              w_t_force;
   logic              w_h_gnt;
   logic              w_t_gnt;
   logic              w_any_gnt;
   logic              w_rd_gnt;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [3:0] sat_inc_streak(input logic [3:0] v);
      return (v >= MAX_B) ? MAX_B : v + 4'd1;
   endfunction

   // Stage p0: combinational grant; the bank sees no access while reset is held
   assign w_both    = h_req & t_req;
   assign w_t_force = (r_streak == MAX_B);
   assign w_h_gnt   = rst_n & h_req & ~(t_req & w_t_force);
   assign w_t_gnt   = rst_n & t_req & ~w_h_gnt;
   assign w_any_gnt = w_h_gnt | w_t_gnt;
   assign w_rd_gnt  = (w_h_gnt & ~h_we) | (w_t_gnt & ~t_we);

   assign h_gnt = w_h_gnt;
   assign t_gnt = w_t_gnt;
   assign m_ce  = w_any_gnt;
   assign m_we  = (w_h_gnt & h_we) | (w_t_gnt & t_we);

   always_comb begin
      m_addr = r_addr_hold;
      m_din  = r_din_hold;
      if (w_h_gnt) begin
         m_addr = h_addr;
         m_din  = h_wdata;
      end else if (w_t_gnt) begin
         m_addr = t_addr;
         m_din  = t_wdata;
      end
   end

   // Idle cycles keep the last granted address/data on the bus to avoid toggling
   always_ff @(posedge clk) begin
      if (w_any_gnt) begin
         r_addr_hold <= m_addr;
         r_din_hold  <= m_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_streak       <= 4'd0;
         r_conflict_cnt <= 16'd0;
      end else begin
         if (!t_req || w_t_gnt)
            r_streak <= 4'd0;
         else if (w_h_gnt)
            r_streak <= sat_inc_streak(r_streak);
         if (w_both)
            r_conflict_cnt <= sat_inc16(r_conflict_cnt);
      end
   end

   // Stage p1: read owner travels alongside the SRAM's one-cycle read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld_p1  <= 1'b0;
         r_rd_host_p1 <= 1'b0;
      end else begin
         r_rd_vld_p1  <= w_rd_gnt;
         r_rd_host_p1 <= w_h_gnt;
      end
   end

   assign h_rvalid = r_rd_vld_p1 & r_rd_host_p1;
   assign t_rvalid = r_rd_vld_p1 & ~r_rd_host_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_rdata_hold <= '0;
         r_t_rdata_hold <= '0;
      end else begin
         if (h_rvalid)
            r_h_rdata_hold <= m_dout;
         if (t_rvalid)
            r_t_rdata_hold <= m_dout;
      end
   end

   assign h_rdata      = h_rvalid ? m_dout : r_h_rdata_hold;
   assign t_rdata      = t_rvalid ? m_dout : r_t_rdata_hold;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a write-first single-port SRAM model.
module tb_sram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       h_req, h_we, t_req, t_we;
   logic [9:0] h_addr, t_addr;
   logic [7:0] h_wdata, t_wdata;
   logic       h_gnt, h_rvalid, t_gnt, t_rvalid;
   logic [7:0] h_rdata, t_rdata;
   logic       m_ce, m_we;
   logic [9:0] m_addr;
   logic [7:0] m_din, m_dout;
   logic [15:0] conflict_cnt;

   logic       pl_en;
   logic [9:0] pl_addr;
   logic [7:0] pl_data;
   logic [7:0] mem [0:1023];
   logic [7:0] r_dout;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_HOST_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .t_req(t_req), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
      .t_gnt(t_gnt), .t_rvalid(t_rvalid), .t_rdata(t_rdata),
      .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
      .m_dout(m_dout), .conflict_cnt(conflict_cnt)
   );

   // Write-first bank with registered read data
   always @(posedge clk) begin
      if (pl_en)
         mem[pl_addr] <= pl_data;
      else if (m_ce) begin
         if (m_we) begin
            mem[m_addr] <= m_din;
            r_dout      <= m_din;
         end else
            r_dout <= mem[m_addr];
      end
   end
   assign m_dout = r_dout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
      t_req = 0; t_we = 0; t_addr = '0; t_wdata = '0;
      pl_en = 1'b1; pl_addr = 10'h040; pl_data = 8'h11;
      tick();
      pl_addr = 10'h041; pl_data = 8'h22;
      tick();
      pl_en = 1'b0;
      mid();
      chk("rst_h_rvalid", h_rvalid, 0);
      chk("rst_t_rvalid", t_rvalid, 0);
      chk("rst_h_rdata", h_rdata, 0);
      chk("rst_t_rdata", t_rdata, 0);
      chk("rst_m_ce", m_ce, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_conflict", conflict_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Host only: write then read 0x005
      h_req = 1; h_we = 1; h_addr = 10'h005; h_wdata = 8'hA5;
      mid();
      chk("hw_h_gnt", h_gnt, 1);
      chk("hw_t_gnt", t_gnt, 0);
      chk("hw_m_ce", m_ce, 1);
      chk("hw_m_we", m_we, 1);
      chk("hw_m_addr", m_addr, 10'h005);
      chk("hw_m_din", m_din, 8'hA5);
      tick();
      h_we = 0;
      mid();
      chk("hr_h_gnt", h_gnt, 1);
      chk("hr_m_we", m_we, 0);
      chk("hr_no_rvalid_after_write", h_rvalid, 0);
      tick();
      h_req = 0;
      mid();
      chk("hr_h_rvalid", h_rvalid, 1);
      chk("hr_h_rdata", h_rdata, 8'hA5);
      chk("hr_t_rvalid", t_rvalid, 0);
      chk("idle_m_ce", m_ce, 0);
      chk("idle_m_we", m_we, 0);
      chk("idle_m_addr_hold", m_addr, 10'h005);
      tick();
      mid();
      chk("hr_rvalid_drop", h_rvalid, 0);
      chk("hr_rdata_hold", h_rdata, 8'hA5);
      tick();

      // Tile only: back-to-back reads 0x040, 0x041
      t_req = 1; t_we = 0; t_addr = 10'h040;
      mid();
      chk("tr0_t_gnt", t_gnt, 1);
      chk("tr0_h_gnt", h_gnt, 0);
      tick();
      t_addr = 10'h041;
      mid();
      chk("tr1_t_gnt", t_gnt, 1);
      chk("tr0_t_rvalid", t_rvalid, 1);
      chk("tr0_t_rdata", t_rdata, 8'h11);
      tick();
      t_req = 0;
      mid();
      chk("tr1_t_rvalid", t_rvalid, 1);
      chk("tr1_t_rdata", t_rdata, 8'h22);
      chk("tr_h_rvalid", h_rvalid, 0);
      chk("tr_h_rdata_hold", h_rdata, 8'hA5);
      tick();
      mid();
      chk("tr_rvalid_drop", t_rvalid, 0);
      tick();

      // Contention for 10 cycles: H,H,H,H,T,H,H,H,H,T
      h_req = 1; h_we = 0; h_addr = 10'h040;
      t_req = 1; t_we = 0; t_addr = 10'h041;
      for (int i = 0; i < 10; i++) begin
         mid();
         chk($sformatf("cont_h_gnt_%0d", i), h_gnt, (i == 4 || i == 9) ? 0 : 1);
         chk($sformatf("cont_t_gnt_%0d", i), t_gnt, (i == 4 || i == 9) ? 1 : 0);
         if (i == 1) begin
            chk("cont_h_rvalid", h_rvalid, 1);
            chk("cont_h_rdata", h_rdata, 8'h11);
         end
         if (i == 5)
            chk("cont_t_rvalid_after_force", t_rvalid, 1);
         tick();
      end
      h_req = 0; t_req = 0;
      mid();
      chk("cont_conflict_10", conflict_cnt, 10);
      chk("cont_last_t_rvalid", t_rvalid, 1);
      chk("cont_last_t_rdata", t_rdata, 8'h22);
      chk("none_m_ce", m_ce, 0);
      tick();

      // Streak cleared by a cycle without t_req
      h_req = 1; t_req = 1;
      tick();
      tick();
      t_req = 0;
      tick();
      t_req = 1;
      for (int i = 0; i < 5; i++) begin
         mid();
         if (i == 3) chk("clr_h_gnt_3", h_gnt, 1);
         if (i == 4) chk("clr_t_gnt_4", t_gnt, 1);
         tick();
      end
      h_req = 0; t_req = 0;
      mid();
      chk("clr_conflict_17", conflict_cnt, 17);
      tick();

      // Host write 0x3FF then tile read of the same address
      h_req = 1; h_we = 1; h_addr = 10'h3FF; h_wdata = 8'h7E;
      mid();
      chk("raw_h_gnt", h_gnt, 1);
      tick();
      h_req = 0; t_req = 1; t_we = 0; t_addr = 10'h3FF;
      mid();
      chk("raw_t_gnt", t_gnt, 1);
      tick();
      t_req = 0;
      mid();
      chk("raw_t_rvalid", t_rvalid, 1);
      chk("raw_t_rdata", t_rdata, 8'h7E);
      tick();

      // Reset arriving just after a host read grant
      h_req = 1; h_we = 0; h_addr = 10'h005;
      mid();
      chk("rmid_h_gnt", h_gnt, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rmid_h_rvalid", h_rvalid, 0);
      chk("rmid_conflict", conflict_cnt, 0);
      chk("rmid_m_ce", m_ce, 0);
      chk("rmid_h_gnt_in_reset", h_gnt, 0);
      chk("rmid_h_rdata", h_rdata, 0);
      tick();
      h_req = 0;
      tick();
      rst_n = 1'b1;
      mid();
      chk("rmid_post_h_rvalid", h_rvalid, 0);
      tick();
      mid();
      chk("rmid_post2_h_rvalid", h_rvalid, 0);
      chk("rmid_post2_t_rvalid", t_rvalid, 0);
      tick();

      // Conflict counter saturation
      h_req = 1; t_req = 1; h_we = 0; t_we = 0;
      for (int i = 0; i < 65534; i++) tick();
      chk("sat_fffe", conflict_cnt, 16'hFFFE);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_ffff", conflict_cnt, 16'hFFFF);
      h_req = 0; t_req = 0;
      tick();
      chk("sat_hold", conflict_cnt, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
